insn_mem: RTL
=============

Name: insn_mem

Overview:
- Instruction-memory responder at the far end of the fetch interface.
- Accepts a byte address from the fetch stage and returns the 32-bit instruction word one cycle later.
- Contents are loaded at boot through a byte-serial program-load port, which is assembled little-endian into words.
- Fetches are served only after a load completes. Unserviceable fetches return a NOP with an error flag.

Parameters:
- ADDR_WIDTH, 32, width of the fetch byte address.
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 4.
- NOP_INSN, 32'h00000013, word returned for invalid or errored fetches.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch request strobe, sampled every cycle.
- fetch_pc  in  ADDR_WIDTH  byte address of the instruction to fetch.
- insn  out  32  fetched instruction word (registered).
- insn_valid  out  1  insn carries a response for the request issued the previous cycle.
- insn_err  out  1  the response is misaligned or out of range; insn = NOP_INSN.
- load_start  in  1  pulse: begin a new program load.
- load_valid  in  1  load_data holds a valid byte this cycle.
- load_data  in  8  program byte, in ascending address order.
- load_last  in  1  qualifies load_valid; this byte is the final byte of the image.
- load_busy  out  1  high while in the LOAD state.
- load_done  out  1  one-cycle pulse when a load completes.
- load_ovf  out  1  sticky: bytes were dropped because the image exceeded DEPTH_WORDS.
- load_count  out  clog2(DEPTH_WORDS)+1  number of words written by the current or most recent load.

Behaviour:
- States: IDLE, LOAD, READY.
  - Reset enters IDLE.
  - load_start moves IDLE, READY or LOAD to LOAD.
  - LOAD moves to READY on the cycle after the load_valid&load_last byte is absorbed.
- Reset values:
  - insn = NOP_INSN; insn_valid, insn_err, load_busy, load_done, load_ovf = 0; load_count = 0.
  - Byte counter and word pointer = 0; assembly register = 0.
  - Memory array contents are not reset.
- Reset asserted mid-load: the load is abandoned and the state returns to IDLE. Already-written words remain but are unreachable until a new load completes.
- On entering LOAD via load_start:
  - Clear the byte counter, word pointer, load_count and load_ovf.
  - load_busy = 1 from the next cycle.
  - A load_valid byte in the same cycle as load_start is ignored.
- In LOAD, each load_valid byte:
  - Is written into assembly lane byte_cnt (lane 0 = bits 7:0).
  - byte_cnt increments mod 4.
  - When lane 3 is filled, the word is written to mem[word_ptr]; word_ptr and load_count increment in the same cycle.
- load_last with a partial word: unfilled lanes are zero, the word is written, and load_count increments.
- Overflow: once word_ptr = DEPTH_WORDS, further bytes are discarded and load_ovf is set. load_ovf holds through READY until the next load_start or reset.
- Completion: load_done pulses exactly one cycle, coincident with the first READY cycle. load_busy falls in that same cycle.
- Fetch in READY: fetch_req in cycle N produces the response in cycle N+1, always with insn_valid = 1. The response is one of:
  - Misaligned (fetch_pc[1:0] != 0): insn = NOP_INSN, insn_err = 1.
  - Out of range (word index fetch_pc[ADDR_WIDTH-1:2] >= DEPTH_WORDS): insn = NOP_INSN, insn_err = 1.
  - Otherwise: insn = mem[fetch_pc[2+clog2(DEPTH_WORDS)-1:2]], insn_err = 0.
- Back-to-back: fetch_req may be high every cycle; throughput is one word per cycle.
- fetch_req outside READY: next cycle insn_valid = 0, insn_err = 0, insn = NOP_INSN.
- No fetch_req: next cycle insn_valid = 0, insn_err = 0, and insn holds its previous value.
- fetch_req together with load_start in READY: load_start wins. The fetch is dropped, with insn_valid = 0 next cycle.
- Read during write: not possible, since fetches are not served in LOAD.

Test Plan:
- Reset then idle fetch: fetch_req=1, fetch_pc=0 while in IDLE -> next cycle insn_valid=0, insn=32'h00000013, load_busy=0.
- Load 8 bytes 13 05 a0 00 93 05 10 00 with last on the 8th byte -> load_count=2, load_done pulses once, then:
  - fetch pc=0 -> insn=32'h00a00513, err=0, one cycle later.
  - fetch pc=4 -> insn=32'h00100593.
- Partial word: load 5 bytes EF BE AD DE 11 with last -> load_count=2; fetch pc=4 -> insn=32'h00000011.
- Errors after a load:
  - pc=2 -> valid=1, err=1, insn=NOP.
  - pc=4*DEPTH_WORDS -> valid=1, err=1, insn=NOP.
- Overflow with DEPTH_WORDS=4: load 20 bytes -> load_count=4, load_ovf=1 after done; fetch pc=12 returns word 3; a new load_start clears load_ovf.
- Back-to-back fetches pc=0,4,0 on three consecutive cycles -> three consecutive valid responses in order. Then assert load_start with fetch_req in the same cycle -> insn_valid=0 next cycle and load_busy=1.

Source files
------------

// File: rtl/insn_mem_if.sv
// Fetch-side bus between the fetch stage (master) and the instruction memory (slave).
interface insn_mem_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [31:0]           insn;
  logic                  insn_valid;
  logic                  insn_err;

  modport master (output fetch_req, fetch_pc, input insn, insn_valid, insn_err);
  modport slave  (input fetch_req, fetch_pc, output insn, insn_valid, insn_err);
endinterface

// File: rtl/insn_mem.sv
// Instruction memory: byte-serial little-endian program load, then single-cycle
// registered fetch responses with NOP + error for misaligned/out-of-range addresses.
module insn_mem #(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] NOP_INSN    = 32'h00000013
) (
  input  logic                         clk,
  input  logic                         reset,
  insn_mem_if.slave                    fbus,
  input  logic                         load_start,
  input  logic                         load_valid,
  input  logic [7:0]                   load_data,
  input  logic                         load_last,
  output logic                         load_busy,
  output logic                         load_done,
  output logic                         load_ovf,
  output logic [$clog2(DEPTH_WORDS):0] load_count
);
  localparam int IDXW = $clog2(DEPTH_WORDS);
  localparam logic [IDXW:0] FULL_PTR = (IDXW+1)'(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  logic [31:0] mem [DEPTH_WORDS];

  logic [1:0]  state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [IDXW:0] ptr_q, ptr_d;
  logic [31:0] asm_q, asm_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;
  logic        we;
  logic [31:0] wdata;

  logic [31:0] insn_q;
  logic        valid_q, err_q;
  logic        fetch_ok, misalign, oor;
  logic [IDXW-1:0] ridx;

  // Assembly register only ever holds filled lanes, so OR-ing the new byte in
  // also leaves unfilled upper lanes zero for a short final word.
  assign wdata = asm_q | ({24'h0, load_data} << {byte_cnt_q, 3'b000});

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    ptr_d      = ptr_q;
    asm_d      = asm_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    we         = 1'b0;
    if (load_start) begin
      state_d    = S_LOAD;
      byte_cnt_d = '0;
      ptr_d      = '0;
      asm_d      = '0;
      ovf_d      = 1'b0;
    end else if (state_q == S_LOAD && load_valid) begin
      if (ptr_q == FULL_PTR) begin
        ovf_d = 1'b1;
      end else if (byte_cnt_q == 2'd3 || load_last) begin
        we         = 1'b1;
        ptr_d      = ptr_q + 1'b1;
        asm_d      = '0;
        byte_cnt_d = '0;
      end else begin
        asm_d      = wdata;
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
      if (load_last) begin
        state_d = S_READY;
        done_d  = 1'b1;
      end
    end
  end

  assign fetch_ok = (state_q == S_READY) && fbus.fetch_req && !load_start;
  assign misalign = |fbus.fetch_pc[1:0];
  assign oor      = |(fbus.fetch_pc[ADDR_WIDTH-1:2] >> IDXW);
  assign ridx     = fbus.fetch_pc[IDXW+1:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      ptr_q      <= '0;
      asm_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      insn_q     <= NOP_INSN;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      ptr_q      <= ptr_d;
      asm_q      <= asm_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      valid_q    <= fetch_ok;
      if (fetch_ok) begin
        err_q  <= misalign | oor;
        insn_q <= (misalign | oor) ? NOP_INSN : mem[ridx];
      end else begin
        err_q <= 1'b0;
        if (fbus.fetch_req) insn_q <= NOP_INSN;
      end
    end
  end

  // Array is not reset; a write racing reset is suppressed so it cannot land.
  always_ff @(posedge clk) begin
    if (we && !reset) mem[ptr_q[IDXW-1:0]] <= wdata;
  end

  assign fbus.insn       = insn_q;
  assign fbus.insn_valid = valid_q;
  assign fbus.insn_err   = err_q;
  assign load_busy       = (state_q == S_LOAD);
  assign load_done       = done_q;
  assign load_ovf        = ovf_q;
  assign load_count      = ptr_q;
endmodule
